sseg_scan_mux: RTL and testbench

Multiplexed scan driver for an NDIG-digit common-anode seven-segment display. It latches a packed BCD/hex value, time-multiplexes it one digit at a time, and drives the 4-bit BCD input of the downstream `bcd_7seg` decoder plus the active-low anode enables and decimal point. New values are double-buffered and applied only at frame boundaries, so a frame never mixes digits from two values. A guard interval at the start of each digit slot suppresses ghosting.

---
 rtl/sseg_scan_mux.sv | 121 ++++++++++++
 tb/tb_sseg_scan_mux.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_mux.sv
// Multiplexed scan driver for an NDIG-digit common-anode seven-segment display,
// with frame-aligned double buffering and an anti-ghosting guard at each slot start.
// Define SSEG_LZB_EN to enable leading-zero blanking.
module sseg_scan_mux #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 1000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [4*NDIG-1:0]   VALUE,
    input  logic [NDIG-1:0]     DP_IN,
    input  logic                LOAD,
    output logic [3:0]          BCD,
    output logic [NDIG-1:0]     AN,
    output logic                DP,
    output logic                PENDING
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [4*NDIG-1:0]  sh_val;
    logic [NDIG-1:0]    sh_dp;
    logic [4*NDIG-1:0]  act_val;
    logic [NDIG-1:0]    act_dp;
    logic               pend;

    logic               slot_end;
    logic               wrap;
    logic [NDIG-1:0]    blank;
    logic [3:0]         bcd_p0;
    logic [NDIG-1:0]    an_p0;
    logic               dp_p0;

    assign slot_end = (cnt == LAST_CNT);
    assign wrap     = slot_end && (idx == LAST_IDX);
    assign PENDING  = pend;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            idx     <= '0;
            sh_val  <= '0;
            sh_dp   <= '0;
            act_val <= '0;
            act_dp  <= '0;
            pend    <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (LOAD) begin
                sh_val <= VALUE;
                sh_dp  <= DP_IN;
            end

            // A LOAD coinciding with the wrap bypasses the shadow so it is not lost.
            if (wrap) begin
                pend <= 1'b0;
                if (LOAD) begin
                    act_val <= VALUE;
                    act_dp  <= DP_IN;
                end else if (pend) begin
                    act_val <= sh_val;
                    act_dp  <= sh_dp;
                end
            end else if (LOAD) begin
                pend <= 1'b1;
            end
        end
    end

`ifdef SSEG_LZB_EN
    logic zero_above;

    // Digit i is blanked when it and every more significant nibble are zero.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NDIG - 1; i > 0; i--) begin
            zero_above = zero_above && (act_val[4*i +: 4] == 4'd0);
            blank[i]   = zero_above;
        end
    end
`else
    assign blank = '0;
`endif

    // Stage p0: decode current slot into display drive
    always_comb begin
        bcd_p0 = act_val[4*idx +: 4];
        an_p0  = '1;
        dp_p0  = 1'b1;
        if (!blank[idx]) begin
            dp_p0 = ~act_dp[idx];
            if (int'(cnt) >= GUARD)
                an_p0[idx] = 1'b0;
        end
    end

    // Stage p1: registered outputs, all three updated on the same edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            BCD <= 4'd0;
            AN  <= '1;
            DP  <= 1'b1;
        end else begin
            BCD <= bcd_p0;
            AN  <= an_p0;
            DP  <= dp_p0;
        end
    end
endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with NDIG=4, REFRESH_DIV=8, GUARD=2 (32-cycle frame).
module tb_sseg_scan_mux;
    localparam int NDIG        = 4;
    localparam int REFRESH_DIV = 8;
    localparam int GUARD       = 2;
    localparam int FRAME       = NDIG * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        dp;
    logic        pending;

    int n_vec = 0;
    int n_err = 0;
    int pos   = -1;

    sseg_scan_mux #(
        .NDIG(NDIG), .REFRESH_DIV(REFRESH_DIV), .GUARD(GUARD)
    ) dut (
        .CLK(clk), .RST(rst), .VALUE(value), .DP_IN(dp_in), .LOAD(load),
        .BCD(bcd), .AN(an), .DP(dp), .PENDING(pending)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s pos=%0d got=%0h exp=%0h", tag, pos, got, exp);
        end
    endtask

    // Output after each edge reflects frame position pos (cnt = pos%8, idx = pos/8).
    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic goto_pos(input int p);
        while (pos % FRAME != p) tick();
    endtask

    // Walk one full frame and check every cycle against the expected scan pattern.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] d,
                               input logic [3:0] blk, input logic exp_pend);
        logic [3:0] exp_an;
        logic       exp_dp;
        int         di;
        int         c;
        for (int p = 0; p < FRAME; p++) begin
            tick();
            di = p / REFRESH_DIV;
            c  = p % REFRESH_DIV;
            exp_an = 4'b1111;
            if (c >= GUARD && !blk[di]) exp_an[di] = 1'b0;
            exp_dp = blk[di] ? 1'b1 : ~d[di];
            check_val("frame_an", an, exp_an);
            check_val("frame_bcd", bcd, 32'((v >> (4 * di)) & 16'hF));
            check_val("frame_dp", dp, exp_dp);
            check_val("frame_pend", pending, exp_pend);
        end
    endtask

    logic [3:0] blk_0050;
    logic [3:0] blk_0000;

    initial begin
`ifdef SSEG_LZB_EN
        blk_0050 = 4'b1100;
        blk_0000 = 4'b1110;
`else
        blk_0050 = 4'b0000;
        blk_0000 = 4'b0000;
`endif
        // reset state
        tick();
        tick();
        check_val("rst_an", an, 4'b1111);
        check_val("rst_bcd", bcd, 4'h0);
        check_val("rst_dp", dp, 1'b1);
        check_val("rst_pend", pending, 1'b0);

        rst = 1'b0;
        pos = -1;
        tick();
        check_val("post_rst_guard0", an, 4'b1111);
        tick();
        check_val("post_rst_guard1", an, 4'b1111);
        tick();
        check_val("post_rst_an", an, 4'b1110);
        check_val("post_rst_bcd", bcd, 4'h0);

        // mid-frame LOAD waits for the wrap
        value = 16'h1234; dp_in = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        check_val("pend_rise", pending, 1'b1);
        goto_pos(30);
        check_val("pend_hold", pending, 1'b1);
        check_val("old_bcd", bcd, 4'h0);
        tick();
        check_val("pend_fall", pending, 1'b0);
        check_frame(16'h1234, 4'b0100, 4'b0000, 1'b0);

        // last write before the wrap wins
        tick();
        value = 16'hAAAA; dp_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_val("no_early_apply", bcd, 4'h4);
        goto_pos(6);
        value = 16'h5678; load = 1'b1;
        tick();
        load = 1'b0;
        check_val("pend_second", pending, 1'b1);
        goto_pos(31);
        check_frame(16'h5678, 4'b0000, 4'b0000, 1'b0);

        // LOAD exactly on the wrap edge goes straight to the active value
        goto_pos(30);
        check_val("pend_idle", pending, 1'b0);
        value = 16'h9999; load = 1'b1;
        tick();
        load = 1'b0;
        check_val("wrap_load_pend", pending, 1'b0);
        check_frame(16'h9999, 4'b0000, 4'b0000, 1'b0);

        // leading zeros
        goto_pos(30);
        value = 16'h0050; dp_in = 4'b1001; load = 1'b1;
        tick();
        load = 1'b0;
        check_frame(16'h0050, 4'b1001, blk_0050, 1'b0);

        // reset in the digit-2 slot discards a pending value
        goto_pos(3);
        value = 16'h4321; dp_in = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        check_val("pend_before_rst", pending, 1'b1);
        goto_pos(18);
        rst = 1'b1;
        tick();
        tick();
        check_val("mid_rst_an", an, 4'b1111);
        check_val("mid_rst_bcd", bcd, 4'h0);
        check_val("mid_rst_dp", dp, 1'b1);
        check_val("mid_rst_pend", pending, 1'b0);
        rst = 1'b0;
        pos = -1;
        check_frame(16'h0000, 4'b0000, blk_0000, 1'b0);
        check_frame(16'h0000, 4'b0000, blk_0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
